pipeline_ctrl: RTL and testbench

Central sequencer for the five-stage RISC-V pipeline. It owns the write-enables and flush/bubble controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It arbitrates between four sources: load-use hazards seen at ID, taken branch/jump redirects resolved in ID, multi-cycle data-memory accesses in MEM, and external halt/resume requests. It replaces ad-hoc stall logic in the ID stage with one registered state machine.

---
 rtl/pipe_ctrl_pkg.sv | 29 ++
 rtl/pipeline_ctrl_if.sv | 49 ++++
 rtl/hazard_detect.sv | 19 +
 rtl/pipeline_ctrl.sv | 150 +++++++++++++++
 tb/tb_pipeline_ctrl.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline sequencer: state encoding, stage-control bundle
// and default memory timeout.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } pipe_state_e;

    localparam int unsigned MEM_TIMEOUT_DEFAULT = 16;
    localparam int unsigned REG_ADDR_W          = 5;
    localparam int unsigned WAIT_CNT_W          = 8;

    // Per-stage enables plus the NOP-injection controls, MSB first.
    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic idex_write;
        logic exmem_write;
        logic ifid_flush;
        logic idex_bubble;
        logic memwb_bubble;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_RUN    = pipe_ctrl_t'(7'b1111_000);
    localparam pipe_ctrl_t CTRL_FREEZE = pipe_ctrl_t'(7'b0000_001);

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard/handshake inputs and stage controls exchanged between the datapath
// (master) and the pipeline sequencer (slave).
interface pipeline_ctrl_if
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) ();

    logic                  MemRead_ex;
    logic [REG_ADDR_W-1:0] rdAddr_ex;
    logic [REG_ADDR_W-1:0] rs1Addr_id;
    logic [REG_ADDR_W-1:0] rs2Addr_id;
    logic                  rs1Used_id;
    logic                  rs2Used_id;
    logic                  Branch_id;
    logic                  Jump_id;
    logic                  dmem_req_mem;
    logic                  dmem_ready;
    logic                  halt_req;
    logic                  resume;

    logic                  PCWrite;
    logic                  IFIDWrite;
    logic                  IDEXWrite;
    logic                  EXMEMWrite;
    logic                  IFIDFlush;
    logic                  IDEXBubble;
    logic                  MEMWBBubble;
    logic                  halted;
    logic                  mem_err;
    logic [CNT_W-1:0]      stall_cnt;
    logic [CNT_W-1:0]      flush_cnt;
    logic [CNT_W-1:0]      memwait_cnt;

    modport master (
        output MemRead_ex, rdAddr_ex, rs1Addr_id, rs2Addr_id, rs1Used_id, rs2Used_id,
               Branch_id, Jump_id, dmem_req_mem, dmem_ready, halt_req, resume,
        input  PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, IFIDFlush, IDEXBubble,
               MEMWBBubble, halted, mem_err, stall_cnt, flush_cnt, memwait_cnt
    );

    modport slave (
        input  MemRead_ex, rdAddr_ex, rs1Addr_id, rs2Addr_id, rs1Used_id, rs2Used_id,
               Branch_id, Jump_id, dmem_req_mem, dmem_ready, halt_req, resume,
        output PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, IFIDFlush, IDEXBubble,
               MEMWBBubble, halted, mem_err, stall_cnt, flush_cnt, memwait_cnt
    );

endinterface

// File: rtl/hazard_detect.sv
// Load-use comparator: the load in EX writes a register the ID instruction reads.
// Writes to x0 never create a dependency.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic                  mem_read_ex,
    input  logic [REG_ADDR_W-1:0] rd_addr_ex,
    input  logic [REG_ADDR_W-1:0] rs1_addr_id,
    input  logic [REG_ADDR_W-1:0] rs2_addr_id,
    input  logic                  rs1_used_id,
    input  logic                  rs2_used_id,
    output logic                  load_use_c
);

    assign load_use_c = mem_read_ex && (rd_addr_ex != '0) &&
                        ((rs1_used_id && (rd_addr_ex == rs1_addr_id)) ||
                         (rs2_used_id && (rd_addr_ex == rs2_addr_id)));

endmodule

// File: rtl/pipeline_ctrl.sv
// Central five-stage pipeline sequencer (RUN / MEM_WAIT / HALT).
// Define PIPE_PERF_CNT_EN to build the stall/flush/memwait performance counters.
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
    parameter int unsigned CNT_W       = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    pipeline_ctrl_if.slave  bus
);

    pipe_state_e           state_q, state_d;
    logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d, wait_cnt_inc;
    logic                  halt_pend_q, halt_pend_d;
    logic                  mem_err_q, mem_err_d;
    logic                  load_use_c;
    pipe_ctrl_t            ctrl;

    hazard_detect u_hazard_detect (
        .mem_read_ex (bus.MemRead_ex),
        .rd_addr_ex  (bus.rdAddr_ex),
        .rs1_addr_id (bus.rs1Addr_id),
        .rs2_addr_id (bus.rs2Addr_id),
        .rs1_used_id (bus.rs1Used_id),
        .rs2_used_id (bus.rs2Used_id),
        .load_use_c  (load_use_c)
    );

    assign wait_cnt_inc = wait_cnt_q + WAIT_CNT_W'(1);

    // Next state and same-cycle stage controls.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        halt_pend_d = halt_pend_q;
        mem_err_d   = mem_err_q;
        ctrl        = CTRL_RUN;
        case (state_q)
            RUN: begin
                if (bus.dmem_req_mem && !bus.dmem_ready) begin
                    ctrl       = CTRL_FREEZE;
                    state_d    = MEM_WAIT;
                    wait_cnt_d = WAIT_CNT_W'(1);
                end else if (load_use_c) begin
                    // Redirect operands are stale while the load is in EX.
                    ctrl.pc_write    = 1'b0;
                    ctrl.ifid_write  = 1'b0;
                    ctrl.idex_bubble = 1'b1;
                end else if (bus.Branch_id || bus.Jump_id) begin
                    ctrl.ifid_flush = 1'b1;
                end else if (bus.halt_req) begin
                    state_d = HALT;
                end
            end
            MEM_WAIT: begin
                if (bus.halt_req) begin
                    halt_pend_d = 1'b1;
                end
                if (bus.dmem_ready) begin
                    wait_cnt_d = '0;
                    if (halt_pend_q || bus.halt_req) begin
                        state_d     = HALT;
                        halt_pend_d = 1'b0;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    ctrl       = CTRL_FREEZE;
                    wait_cnt_d = wait_cnt_inc;
                    if (wait_cnt_inc == WAIT_CNT_W'(MEM_TIMEOUT)) begin
                        mem_err_d   = 1'b1;
                        state_d     = HALT;
                        halt_pend_d = 1'b0;
                        wait_cnt_d  = '0;
                    end
                end
            end
            HALT: begin
                ctrl        = CTRL_FREEZE;
                halt_pend_d = 1'b0;
                if (bus.resume && !bus.halt_req) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            halt_pend_q <= 1'b0;
            mem_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            halt_pend_q <= halt_pend_d;
            mem_err_q   <= mem_err_d;
        end
    end

    assign bus.PCWrite     = ctrl.pc_write;
    assign bus.IFIDWrite   = ctrl.ifid_write;
    assign bus.IDEXWrite   = ctrl.idex_write;
    assign bus.EXMEMWrite  = ctrl.exmem_write;
    assign bus.IFIDFlush   = ctrl.ifid_flush;
    assign bus.IDEXBubble  = ctrl.idex_bubble;
    assign bus.MEMWBBubble = ctrl.memwb_bubble;
    assign bus.halted      = (state_q == HALT);
    assign bus.mem_err     = mem_err_q;

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] memwait_cnt_q, memwait_cnt_d;

    // Memory freeze cycles only; HALT also drives MEMWBBubble but is not counted.
    always_comb begin
        stall_cnt_d   = stall_cnt_q + CNT_W'(ctrl.idex_bubble);
        flush_cnt_d   = flush_cnt_q + CNT_W'(ctrl.ifid_flush);
        memwait_cnt_d = memwait_cnt_q + CNT_W'(ctrl.memwb_bubble && (state_q != HALT));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
            memwait_cnt_q <= '0;
        end else begin
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
            memwait_cnt_q <= memwait_cnt_d;
        end
    end

    assign bus.stall_cnt   = stall_cnt_q;
    assign bus.flush_cnt   = flush_cnt_q;
    assign bus.memwait_cnt = memwait_cnt_q;
`else
    assign bus.stall_cnt   = CNT_W'(0);
    assign bus.flush_cnt   = CNT_W'(0);
    assign bus.memwait_cnt = CNT_W'(0);
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: hazards, redirects, memory waits, halt and reset.
module tb_pipeline_ctrl;

`ifdef PIPE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // {PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, IFIDFlush, IDEXBubble, MEMWBBubble}
    localparam logic [6:0] C_RUN    = 7'b1111_000;
    localparam logic [6:0] C_FREEZE = 7'b0000_001;
    localparam logic [6:0] C_STALL  = 7'b0011_010;
    localparam logic [6:0] C_FLUSH  = 7'b1111_100;

    logic        clk;
    logic        rst_n;
    int unsigned n_checks;
    int unsigned n_errors;

    pipeline_ctrl_if #(.CNT_W(32)) bus ();

    pipeline_ctrl #(.MEM_TIMEOUT(16), .CNT_W(32)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.MemRead_ex   = 1'b0;
        bus.rdAddr_ex    = 5'd0;
        bus.rs1Addr_id   = 5'd0;
        bus.rs2Addr_id   = 5'd0;
        bus.rs1Used_id   = 1'b0;
        bus.rs2Used_id   = 1'b0;
        bus.Branch_id    = 1'b0;
        bus.Jump_id      = 1'b0;
        bus.dmem_req_mem = 1'b0;
        bus.dmem_ready   = 1'b0;
        bus.halt_req     = 1'b0;
        bus.resume       = 1'b0;
    endtask

    function automatic logic [31:0] ctrl_vec();
        return 32'({bus.PCWrite, bus.IFIDWrite, bus.IDEXWrite, bus.EXMEMWrite,
                    bus.IFIDFlush, bus.IDEXBubble, bus.MEMWBBubble});
    endfunction

    function automatic logic [31:0] perf(input int unsigned n);
        return PERF ? 32'(n) : 32'd0;
    endfunction

    task automatic check_ctrl(input string tag, input logic [6:0] exp);
        #1;
        check(tag, ctrl_vec(), 32'(exp));
    endtask

    task automatic load_use(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                            input logic [4:0] rs2, input logic u2);
        bus.MemRead_ex = 1'b1;
        bus.rdAddr_ex  = rd;
        bus.rs1Addr_id = rs1;
        bus.rs1Used_id = u1;
        bus.rs2Addr_id = rs2;
        bus.rs2Used_id = u2;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        idle();
        rst_n = 1'b0;
        tick();
        check_ctrl("rst_ctrl", C_RUN);
        check("rst_halted", 32'(bus.halted), 32'd0);
        check("rst_mem_err", 32'(bus.mem_err), 32'd0);
        check("rst_cnt", bus.stall_cnt | bus.flush_cnt | bus.memwait_cnt, 32'd0);
        #2 rst_n = 1'b1;
        tick();

        // Load-use hazards
        load_use(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
        check_ctrl("lu_rs1", C_STALL);
        tick(); idle();
        check_ctrl("lu_one_cycle", C_RUN);
        check("lu_stall_cnt1", bus.stall_cnt, perf(1));
        load_use(5'd0, 5'd0, 1'b1, 5'd0, 1'b0);
        check_ctrl("lu_x0", C_RUN);
        tick(); idle();
        load_use(5'd7, 5'd3, 1'b1, 5'd7, 1'b1);
        check_ctrl("lu_rs2", C_STALL);
        tick(); idle();
        load_use(5'd7, 5'd3, 1'b0, 5'd7, 1'b0);
        check_ctrl("lu_unused", C_RUN);
        tick(); idle();
        bus.rdAddr_ex = 5'd5; bus.rs1Addr_id = 5'd5; bus.rs1Used_id = 1'b1;
        check_ctrl("lu_not_load", C_RUN);
        tick(); idle();
        check("lu_stall_cnt2", bus.stall_cnt, perf(2));

        // Redirects
        bus.Branch_id = 1'b1;
        check_ctrl("br_flush", C_FLUSH);
        tick(); idle();
        check_ctrl("br_one_cycle", C_RUN);
        check("br_flush_cnt1", bus.flush_cnt, perf(1));
        bus.Jump_id = 1'b1;
        check_ctrl("jmp_flush", C_FLUSH);
        tick(); idle();
        bus.Branch_id = 1'b1;
        load_use(5'd9, 5'd9, 1'b1, 5'd0, 1'b0);
        check_ctrl("br_vs_lu", C_STALL);
        tick(); idle();
        check("br_flush_cnt2", bus.flush_cnt, perf(2));
        check("br_stall_cnt3", bus.stall_cnt, perf(3));

        // Three-cycle memory wait
        bus.dmem_req_mem = 1'b1;
        check_ctrl("mw_c1", C_FREEZE);
        tick();
        check_ctrl("mw_c2", C_FREEZE);
        tick();
        check_ctrl("mw_c3", C_FREEZE);
        tick();
        bus.dmem_ready = 1'b1;
        check_ctrl("mw_ready", C_RUN);
        tick(); idle();
        check_ctrl("mw_back_run", C_RUN);
        check("mw_halted", 32'(bus.halted), 32'd0);
        check("mw_memwait_cnt", bus.memwait_cnt, perf(3));

        // halt_req during MEM_WAIT is deferred to after the ready cycle
        bus.dmem_req_mem = 1'b1;
        check_ctrl("hp_c1", C_FREEZE);
        tick();
        bus.halt_req = 1'b1;
        check_ctrl("hp_c2", C_FREEZE);
        tick();
        bus.halt_req = 1'b0; bus.dmem_ready = 1'b1;
        check_ctrl("hp_ready", C_RUN);
        check("hp_not_yet", 32'(bus.halted), 32'd0);
        tick(); idle();
        check("hp_halted", 32'(bus.halted), 32'd1);
        check_ctrl("hp_halt_ctrl", C_FREEZE);
        check("hp_memwait_cnt", bus.memwait_cnt, perf(5));
        bus.resume = 1'b1; bus.halt_req = 1'b1;
        tick();
        check("hp_resume_ignored", 32'(bus.halted), 32'd1);
        bus.halt_req = 1'b0;
        tick(); idle();
        check("hp_resumed", 32'(bus.halted), 32'd0);
        check_ctrl("hp_run_ctrl", C_RUN);

        // Simultaneous dmem_ready and halt_req
        bus.dmem_req_mem = 1'b1;
        tick();
        bus.dmem_ready = 1'b1; bus.halt_req = 1'b1;
        check_ctrl("sim_ready", C_RUN);
        tick(); idle();
        check("sim_halted", 32'(bus.halted), 32'd1);
        bus.resume = 1'b1;
        tick(); idle();
        check("sim_resumed", 32'(bus.halted), 32'd0);

        // halt_req in RUN lets the current cycle complete
        bus.halt_req = 1'b1;
        check_ctrl("run_halt_ctrl", C_RUN);
        tick(); bus.halt_req = 1'b0;
        check("run_halted", 32'(bus.halted), 32'd1);
        bus.resume = 1'b1;
        tick(); idle();

        // Memory timeout after 16 freeze cycles
        bus.dmem_req_mem = 1'b1;
        check_ctrl("to_c1", C_FREEZE);
        for (int i = 0; i < 15; i++) tick();
        check("to_err_c16", 32'(bus.mem_err), 32'd0);
        check("to_halt_c16", 32'(bus.halted), 32'd0);
        check_ctrl("to_ctrl_c16", C_FREEZE);
        tick();
        check("to_err", 32'(bus.mem_err), 32'd1);
        check("to_halted", 32'(bus.halted), 32'd1);
        check("to_memwait_cnt", bus.memwait_cnt, perf(22));
        idle(); bus.resume = 1'b1;
        tick(); idle();
        check("to_resumed", 32'(bus.halted), 32'd0);
        check("to_err_sticky", 32'(bus.mem_err), 32'd1);
        check_ctrl("to_run_ctrl", C_RUN);

        // Asynchronous reset while in HALT
        bus.halt_req = 1'b1;
        tick(); bus.halt_req = 1'b0;
        check("ar_pre_halted", 32'(bus.halted), 32'd1);
        rst_n = 1'b0;
        #2;
        check("ar_halted", 32'(bus.halted), 32'd0);
        check("ar_mem_err", 32'(bus.mem_err), 32'd0);
        check("ar_cnt", bus.stall_cnt | bus.flush_cnt | bus.memwait_cnt, 32'd0);
        check("ar_ctrl", ctrl_vec(), 32'(C_RUN));
        #1 rst_n = 1'b1;
        tick();

        // Asynchronous reset while in MEM_WAIT
        bus.dmem_req_mem = 1'b1;
        tick(); idle();
        check_ctrl("arm_in_wait", C_FREEZE);
        rst_n = 1'b0;
        #1;
        check("arm_ctrl", ctrl_vec(), 32'(C_RUN));
        #1 rst_n = 1'b1;
        tick();
        check_ctrl("arm_after", C_RUN);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
